hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO register pair. It sits beside the ALU in the datapath. It consumes the register-file operands `srca`/`srcb` for MULT, MULTU, DIV and DIVU, and supplies HI/LO to the result mux for MFHI/MFLO. It replaces the ALU's single-cycle multiply. It asserts `busy` so the controller can stall the PC while an operation runs.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_addsub.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  // Operation select encodings on the op input
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // One shift-add / restoring step per bit of the operands
  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply and divide iteration steps.
// With sub=1 it computes x - y, and cout=1 means no borrow (x >= y).
module muldiv_addsub (
  input  logic [32:0] x,
  input  logic [32:0] y,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);

  logic [32:0] y_eff;
  logic [33:0] total;

  // Conditionally invert the second operand bit by bit for subtraction
  genvar gi;
  generate
    for (gi = 0; gi < 33; gi++) begin : g_inv
      assign y_eff[gi] = y[gi] ^ sub;
    end
  endgenerate

  // Two's complement add; the +1 for subtraction enters as carry-in
  assign total = {1'b0, x} + {1'b0, y_eff} + {33'd0, sub};
  assign sum   = total[32:0];
  assign cout  = total[33];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair. Signed operations run
// on magnitudes and the signs are reapplied in the FIX cycle.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_reg, state_next;
  logic [4:0]         cnt_reg, cnt_next;

  // Latched operation context
  logic               is_div_reg, is_div_next;
  logic               sign_q_reg, sign_q_next;   // sign of product / quotient
  logic               sign_r_reg, sign_r_next;   // sign of remainder
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   a_orig_reg, a_orig_next;   // raw dividend for divide-by-zero HI
  logic [WIDTH-1:0]   opnd_reg, opnd_next;       // multiplicand or divisor magnitude

  // {acc_hi, acc_lo}: product accumulator, or {remainder, quotient}
  logic [WIDTH-1:0]   acc_hi_reg, acc_hi_next;
  logic [WIDTH-1:0]   acc_lo_reg, acc_lo_next;

  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  // Operand magnitudes for signed ops
  logic [WIDTH-1:0]   abs_a, abs_b;
  assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

  // Shared adder: MUL adds multiplicand into acc_hi, DIV trial-subtracts divisor
  logic [WIDTH:0]     as_x, as_y, as_sum;
  logic               as_sub, as_cout;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     mul_sum;

  assign rem_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign as_sub    = (state_reg == DIV);
  assign as_x      = as_sub ? rem_shift : {1'b0, acc_hi_reg};
  assign as_y      = {1'b0, opnd_reg};

  muldiv_addsub u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  // Add only when the current multiplier bit is set
  assign mul_sum = acc_lo_reg[0] ? as_sum : {1'b0, acc_hi_reg};

  // Sign restoration applied when the result is written
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_mag = {acc_hi_reg, acc_lo_reg};
  assign prod_fix = sign_q_reg ? -prod_mag : prod_mag;
  assign quo_fix  = sign_q_reg ? -acc_lo_reg : acc_lo_reg;
  assign rem_fix  = sign_r_reg ? -acc_hi_reg : acc_hi_reg;

  // State and iteration counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: accept in IDLE, iterate until the counter hits zero, then FIX
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = op[1] ? DIV : MUL;
          cnt_next   = 5'(ITER - 1);
        end
      end
      MUL, DIV: begin
        if (cnt_reg == 5'd0) state_next = FIX;
        else                 cnt_next   = cnt_reg - 5'd1;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    is_div_next   = is_div_reg;
    sign_q_next   = sign_q_reg;
    sign_r_next   = sign_r_reg;
    div_zero_next = div_zero_reg;
    a_orig_next   = a_orig_reg;
    opnd_next     = opnd_reg;
    acc_hi_next   = acc_hi_reg;
    acc_lo_next   = acc_lo_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (write_hi) hi_next = wdata;
        if (write_lo) lo_next = wdata;
        if (start) begin
          is_div_next   = op[1];
          sign_q_next   = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          sign_r_next   = op[0] & a[WIDTH-1];
          div_zero_next = (b == '0);
          a_orig_next   = a;
          acc_hi_next   = '0;
          acc_lo_next   = op[1] ? abs_a : abs_b;
          opnd_next     = op[1] ? abs_b : abs_a;
        end
      end
      MUL: begin
        acc_hi_next = mul_sum[WIDTH:1];
        acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
      end
      DIV: begin
        if (as_cout) begin
          acc_hi_next = as_sum[WIDTH-1:0];
          acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_next = rem_shift[WIDTH-1:0];
          acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        done_next = 1'b1;
        if (is_div_reg) begin
          if (div_zero_reg) begin
            hi_next = a_orig_reg;
            lo_next = '1;
          end else begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end
        end else begin
          hi_next = prod_fix[2*WIDTH-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      is_div_reg   <= 1'b0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      a_orig_reg   <= '0;
      opnd_reg     <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      is_div_reg   <= is_div_next;
      sign_q_reg   <= sign_q_next;
      sign_r_reg   <= sign_r_next;
      div_zero_reg <= div_zero_next;
      a_orig_reg   <= a_orig_next;
      opnd_reg     <= opnd_next;
      acc_hi_reg   <= acc_hi_next;
      acc_lo_reg   <= acc_lo_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: scoreboard of expected HI/LO
// pushed at issue time and popped when done pulses.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        write_hi, write_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .write_hi (write_hi),
    .write_lo (write_lo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Reference: returns {HI, LO} from plain SV arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    int sx, sy, q, r;
    case (o)
      2'b00: return {32'd0, x} * {32'd0, y};
      2'b01: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return p;
      end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x; sy = y;
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Drive a start pulse from the current time; optionally push the expected result
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    exp_t e;
    logic [63:0] m;
    if (push) begin
      m = model(o, x, y);
      e.hi = m[63:32];
      e.lo = m[31:0];
      exp_q.push_back(e);
    end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Wait (bounded) for done, counting busy cycles; returns at the done-high negedge
  task automatic collect(output logic [31:0] ohi, output logic [31:0] olo, output int nbusy, output bit tmo);
    nbusy = 0; tmo = 1'b1; ohi = 'x; olo = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ohi = hi; olo = lo; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", hi); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy got %b want 0", busy); end
    $display("[TB] reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_arith();
    vec_t vecs[$];
    vec_t v;
    exp_t e;
    logic [31:0] ohi, olo;
    int nbusy;
    bit tmo;
    vecs.push_back('{op: 2'b00, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF});
    vecs.push_back('{op: 2'b01, a: 32'hFFFF_FFFD, b: 32'h0000_0005});
    vecs.push_back('{op: 2'b11, a: 32'hFFFF_FFF9, b: 32'h0000_0002});
    vecs.push_back('{op: 2'b10, a: 32'h1234_5678, b: 32'h0000_0000});
    vecs.push_back('{op: 2'b11, a: 32'h8000_0000, b: 32'hFFFF_FFFF});
    vecs.push_back('{op: 2'b11, a: 32'h0000_0007, b: 32'hFFFF_FFFE});
    vecs.push_back('{op: 2'b11, a: 32'hFFFF_FFF9, b: 32'h0000_0000});
    vecs.push_back('{op: 2'b01, a: 32'h8000_0000, b: 32'h8000_0000});
    vecs.push_back('{op: 2'b01, a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF});
    vecs.push_back('{op: 2'b10, a: 32'hFFFF_FFFF, b: 32'h0000_0001});
    vecs.push_back('{op: 2'b10, a: 32'h0000_0003, b: 32'h0000_0007});
    for (int i = 0; i < 6; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a  = $urandom;
      v.b  = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      vecs.push_back(v);
    end
    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      collect(ohi, olo, nbusy, tmo);
      e = exp_q.pop_front();
      tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL arith_timeout[%0d] no done within bound", i); end
      tests_run++; if (ohi !== e.hi) begin tests_failed++; $display("FAIL arith_hi[%0d] got %h want %h", i, ohi, e.hi); end
      tests_run++; if (olo !== e.lo) begin tests_failed++; $display("FAIL arith_lo[%0d] got %h want %h", i, olo, e.lo); end
      tests_run++; if (nbusy !== 33) begin tests_failed++; $display("FAIL arith_busy_cycles[%0d] got %0d want 33", i, nbusy); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL arith_done_width[%0d] got %b want 0", i, done); end
      $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", vecs[i].op, vecs[i].a, vecs[i].b, ohi, olo, nbusy);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    wdata = 32'hA5A5_0001; write_hi = 1'b1;
    @(posedge clk); #1; write_hi = 1'b0;
    @(negedge clk);
    tests_run++; if (hi !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL mthi got %h want a5a50001", hi); end
    wdata = 32'h0000_BEEF; write_lo = 1'b1;
    @(posedge clk); #1; write_lo = 1'b0;
    @(negedge clk);
    tests_run++; if (lo !== 32'h0000_BEEF) begin tests_failed++; $display("FAIL mtlo got %h want 0000beef", lo); end
    tests_run++; if (hi !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL mtlo_hi_kept got %h want a5a50001", hi); end
    wdata = 32'h1357_2468; write_hi = 1'b1; write_lo = 1'b1;
    @(posedge clk); #1; write_hi = 1'b0; write_lo = 1'b0;
    @(negedge clk);
    tests_run++; if (hi !== 32'h1357_2468) begin tests_failed++; $display("FAIL mt_both_hi got %h want 13572468", hi); end
    tests_run++; if (lo !== 32'h1357_2468) begin tests_failed++; $display("FAIL mt_both_lo got %h want 13572468", lo); end
    $display("[TB] mthi/mtlo: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_start_with_write();
    exp_t e;
    logic [31:0] ohi, olo;
    int nbusy;
    bit tmo;
    @(negedge clk);
    wdata = 32'h0000_55AA; write_hi = 1'b1;
    issue(2'b00, 32'd3, 32'd4, 1'b1);
    write_hi = 1'b0;
    @(negedge clk);
    tests_run++; if (hi !== 32'h0000_55AA) begin tests_failed++; $display("FAIL start_write_hi got %h want 000055aa", hi); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL start_write_busy got %b want 1", busy); end
    collect(ohi, olo, nbusy, tmo);
    e = exp_q.pop_front();
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL start_write_timeout no done"); end
    tests_run++; if (ohi !== e.hi) begin tests_failed++; $display("FAIL start_write_res_hi got %h want %h", ohi, e.hi); end
    tests_run++; if (olo !== e.lo) begin tests_failed++; $display("FAIL start_write_res_lo got %h want %h", olo, e.lo); end
    $display("[TB] start+mthi: hi=%h lo=%h", ohi, olo);
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", busy); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL abort_hi got %h want 0", hi); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL abort_lo got %h want 0", lo); end
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    tests_run++; if (seen_done !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done got activity=1 want 0"); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL abort_lo_final got %h want 0", lo); end
    $display("[TB] reset abort: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_ignore_while_busy();
    exp_t e;
    logic [31:0] ohi, olo;
    int nbusy;
    bit tmo;
    @(negedge clk);
    issue(2'b00, 32'h0001_0003, 32'h0002_0005, 1'b1);
    repeat (5) @(negedge clk);
    op = 2'b11; a = 32'h0000_0100; b = 32'h0000_0003;
    start = 1'b1; write_hi = 1'b1; write_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    collect(ohi, olo, nbusy, tmo);
    e = exp_q.pop_front();
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL ignore_timeout no done"); end
    tests_run++; if (ohi !== e.hi) begin tests_failed++; $display("FAIL ignore_hi got %h want %h", ohi, e.hi); end
    tests_run++; if (olo !== e.lo) begin tests_failed++; $display("FAIL ignore_lo got %h want %h", olo, e.lo); end
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_no_restart got busy=%b want 0", busy); end
    $display("[TB] ignore while busy: hi=%h lo=%h", ohi, olo);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] ohi, olo;
    int nbusy;
    bit tmo;
    @(negedge clk);
    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b1);
    collect(ohi, olo, nbusy, tmo);
    e = exp_q.pop_front();
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL b2b_first_timeout no done"); end
    tests_run++; if (ohi !== e.hi) begin tests_failed++; $display("FAIL b2b_first_hi got %h want %h", ohi, e.hi); end
    tests_run++; if (olo !== e.lo) begin tests_failed++; $display("FAIL b2b_first_lo got %h want %h", olo, e.lo); end
    $display("[TB] b2b first: hi=%h lo=%h", ohi, olo);
    // Still in the done-high cycle: start is accepted on the next edge
    issue(2'b11, 32'hFFFF_FF9C, 32'd7, 1'b1);
    collect(ohi, olo, nbusy, tmo);
    e = exp_q.pop_front();
    tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_timeout no done"); end
    tests_run++; if (ohi !== e.hi) begin tests_failed++; $display("FAIL b2b_second_hi got %h want %h", ohi, e.hi); end
    tests_run++; if (olo !== e.lo) begin tests_failed++; $display("FAIL b2b_second_lo got %h want %h", olo, e.lo); end
    tests_run++; if (nbusy !== 33) begin tests_failed++; $display("FAIL b2b_second_busy got %0d want 33", nbusy); end
    $display("[TB] b2b second: hi=%h lo=%h busy_cycles=%0d", ohi, olo, nbusy);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mthi_mtlo();
    test_start_with_write();
    test_reset_abort();
    test_ignore_while_busy();
    test_back_to_back();
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
